// File: rtl/washing_ctrl_param_if.sv
// Front-panel/sensor inputs and valve/motor/lock outputs of the washing controller.
interface washing_ctrl_param_if;
    logic       start;
    logic       door_close;
    logic       pause;
    logic       filled;
    logic       detergent_added;
    logic       drained;
    logic       door_lock;
    logic       motor_on;
    logic       fill_valve_on;
    logic       drain_valve_on;
    logic       soap_wash;
    logic       water_wash;
    logic       done;
    logic       fault;
    logic [3:0] state;
    logic [2:0] rinse_left;

    modport master (
        output start, door_close, pause, filled, detergent_added, drained,
        input  door_lock, motor_on, fill_valve_on, drain_valve_on,
               soap_wash, water_wash, done, fault, state, rinse_left
    );

    modport slave (
        input  start, door_close, pause, filled, detergent_added, drained,
        output door_lock, motor_on, fill_valve_on, drain_valve_on,
               soap_wash, water_wash, done, fault, state, rinse_left
    );
endinterface

// File: rtl/washing_ctrl_param.sv
// Washing-machine cycle controller: counted wash/spin, watchdogged fill/drain,
// configurable rinse passes, pause support. Outputs are registered Moore decodes.
module washing_ctrl_param #(
    parameter int unsigned WASH_TIME     = 16,
    parameter int unsigned SPIN_TIME     = 8,
    parameter int unsigned FILL_TIMEOUT  = 32,
    parameter int unsigned DRAIN_TIMEOUT = 32,
    parameter int unsigned RINSE_COUNT   = 2,
    parameter int unsigned CNT_W         = 8
) (
    input logic               clk,
    input logic               reset,
    washing_ctrl_param_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOCK  = 4'd1,
        S_FILL  = 4'd2,
        S_SOAP  = 4'd3,
        S_WASH  = 4'd4,
        S_DRAIN = 4'd5,
        S_SPIN  = 4'd6,
        S_DONE  = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TIME - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TIME - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [2:0]       RINSE_INIT = 3'(RINSE_COUNT);

    state_t           st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       rinse, rinse_nxt;
    logic             paused;
    logic             soap_nxt;

    always_comb begin
        st_nxt    = st;
        rinse_nxt = rinse;
        paused    = 1'b0;
        if ((st inside {S_LOCK, S_FILL, S_SOAP, S_WASH, S_DRAIN, S_SPIN}) && !bus.door_close) begin
            st_nxt = S_FAULT;
        end else if ((st inside {S_FILL, S_SOAP, S_WASH, S_DRAIN, S_SPIN}) && bus.pause) begin
            paused = 1'b1;
        end else begin
            case (st)
                S_IDLE: if (bus.start && bus.door_close) begin
                    st_nxt    = S_LOCK;
                    rinse_nxt = RINSE_INIT;
                end
                S_LOCK: st_nxt = S_FILL;
                S_FILL: begin
                    if (bus.filled)
                        st_nxt = (rinse == RINSE_INIT) ? S_SOAP : S_WASH;
                    else if (cnt == FILL_LAST)
                        st_nxt = S_FAULT;
                end
                S_SOAP: if (bus.detergent_added) st_nxt = S_WASH;
                S_WASH: if (cnt == WASH_LAST) st_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (bus.drained) begin
                        if (rinse != 3'd0) begin
                            rinse_nxt = rinse - 3'd1;
                            st_nxt    = S_FILL;
                        end else begin
                            st_nxt = S_SPIN;
                        end
                    end else if (cnt == DRAIN_LAST) begin
                        st_nxt = S_FAULT;
                    end
                end
                S_SPIN: if (cnt == SPIN_LAST) st_nxt = S_DONE;
                S_DONE: if (!bus.start) st_nxt = S_IDLE;
                default: st_nxt = st;
            endcase
        end

        if (st_nxt != st)
            cnt_nxt = '0;
        else if (paused)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;

        // The soap pass is the one that still has every rinse pass ahead of it.
        soap_nxt = (rinse_nxt == RINSE_INIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st                 <= S_IDLE;
            cnt                <= '0;
            rinse              <= '0;
            bus.door_lock      <= 1'b0;
            bus.motor_on       <= 1'b0;
            bus.fill_valve_on  <= 1'b0;
            bus.drain_valve_on <= 1'b0;
            bus.soap_wash      <= 1'b0;
            bus.water_wash     <= 1'b0;
            bus.done           <= 1'b0;
            bus.fault          <= 1'b0;
            bus.state          <= '0;
            bus.rinse_left     <= '0;
        end else begin
            st                 <= st_nxt;
            cnt                <= cnt_nxt;
            rinse              <= rinse_nxt;
            bus.door_lock      <= st_nxt inside {S_LOCK, S_FILL, S_SOAP, S_WASH,
                                                 S_DRAIN, S_SPIN, S_FAULT};
            bus.motor_on       <= !paused && (st_nxt inside {S_WASH, S_SPIN});
            bus.fill_valve_on  <= !paused && (st_nxt == S_FILL);
            bus.drain_valve_on <= !paused && (st_nxt inside {S_DRAIN, S_SPIN});
            bus.soap_wash      <= soap_nxt && (st_nxt inside {S_FILL, S_SOAP, S_WASH, S_DRAIN});
            bus.water_wash     <= !soap_nxt && (st_nxt inside {S_FILL, S_WASH, S_DRAIN});
            bus.done           <= (st_nxt == S_DONE);
            bus.fault          <= (st_nxt == S_FAULT);
            bus.state          <= st_nxt;
            bus.rinse_left     <= rinse_nxt;
        end
    end

endmodule

// File: tb/tb_washing_ctrl_param.sv
// Bench for washing_ctrl_param: phase/pass reference model checked every cycle,
// directed scenarios with literal expectations, then randomized episodes.
module tb_washing_ctrl_param;

    localparam int WT = 4;
    localparam int ST = 3;
    localparam int FT = 5;
    localparam int DT = 6;
    localparam int RC = 1;
    localparam int CW = 8;
    localparam int CNT_MOD = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_on = 1'b0;
    int   total = 0;
    int   bad = 0;

    washing_ctrl_param_if bus();

    washing_ctrl_param #(
        .WASH_TIME(WT), .SPIN_TIME(ST), .FILL_TIMEOUT(FT),
        .DRAIN_TIMEOUT(DT), .RINSE_COUNT(RC), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // phase uses the published state codes; pass 0 is the soap pass
    typedef struct packed {
        int phase;
        int elapsed;
        int pass;
        bit paused;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(mdl_t c, bit st, bit dc, bit pz, bit fl, bit de, bit dr);
        mdl_t n = c;
        n.paused = 1'b0;
        if (c.phase >= 1 && c.phase <= 6 && !dc) begin
            n.phase = 8;
        end else if (c.phase >= 2 && c.phase <= 6 && pz) begin
            n.paused = 1'b1;
            return n;
        end else begin
            case (c.phase)
                0: if (st && dc) begin n.phase = 1; n.pass = 0; end
                1: n.phase = 2;
                2: if (fl) n.phase = (c.pass == 0) ? 3 : 4;
                   else if (c.elapsed == FT - 1) n.phase = 8;
                3: if (de) n.phase = 4;
                4: if (c.elapsed == WT - 1) n.phase = 5;
                5: if (dr) begin
                       if (c.pass < RC) begin n.pass = c.pass + 1; n.phase = 2; end
                       else n.phase = 6;
                   end else if (c.elapsed == DT - 1) n.phase = 8;
                6: if (c.elapsed == ST - 1) n.phase = 7;
                7: if (!st) n.phase = 0;
                default: ;
            endcase
        end
        n.elapsed = (n.phase != c.phase) ? 0 : (c.elapsed + 1) % CNT_MOD;
        return n;
    endfunction

    function automatic logic [14:0] mexp(mdl_t c);
        int  p   = c.phase;
        bit  run = !c.paused;
        bit  dl  = (p >= 1 && p <= 6) || p == 8;
        bit  mo  = run && (p == 4 || p == 6);
        bit  fv  = run && p == 2;
        bit  dv  = run && (p == 5 || p == 6);
        bit  sw  = c.pass == 0 && p >= 2 && p <= 5;
        bit  ww  = c.pass > 0 && (p == 2 || p == 4 || p == 5);
        return {dl, mo, fv, dv, sw, ww, p == 7, p == 8, 4'(p), 3'(RC - c.pass)};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst)
            m <= mdl_t'{0, 0, RC, 1'b0};
        else
            m <= mstep(m, bus.start, bus.door_close, bus.pause,
                       bus.filled, bus.detergent_added, bus.drained);
    end

    logic [14:0] dut_vec;
    assign dut_vec = {bus.door_lock, bus.motor_on, bus.fill_valve_on, bus.drain_valve_on,
                      bus.soap_wash, bus.water_wash, bus.done, bus.fault,
                      bus.state, bus.rinse_left};

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (dut_vec !== mexp(m)) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got=%b want=%b", $time, dut_vec, mexp(m));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input bit st, input bit dc, input bit pz,
                          input bit fl, input bit de, input bit dr);
        bus.start = st; bus.door_close = dc; bus.pause = pz;
        bus.filled = fl; bus.detergent_added = de; bus.drained = dr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_state(input int code, input int lim, input string nm);
        int n = 0;
        while (int'(bus.state) != code && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(bus.state), code);
    endtask

    int seq [18] = '{1, 2, 3, 4, 4, 4, 4, 5, 2, 4, 4, 4, 4, 5, 6, 6, 6, 7};

    initial begin
        if (WT >= CNT_MOD || ST >= CNT_MOD || FT >= CNT_MOD || DT >= CNT_MOD) begin
            $display("FAIL param_fit: parameters exceed CNT_W");
            $fatal(1);
        end
        set_in(0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_on = 1'b1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_lock", int'(bus.door_lock), 0);

        // nominal two-pass cycle with sensors ready immediately
        set_in(1, 1, 0, 1, 1, 1);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk($sformatf("nom_state[%0d]", i), int'(bus.state), seq[i]);
            chk($sformatf("nom_soap[%0d]", i), int'(bus.soap_wash), int'(i >= 1 && i <= 7));
            chk($sformatf("nom_water[%0d]", i), int'(bus.water_wash), int'(i >= 8 && i <= 13));
        end
        repeat (2) begin
            @(negedge clk);
            chk("nom_done_hold", int'(bus.done), 1);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("nom_idle", int'(bus.state), 0);
        chk("nom_done_clr", int'(bus.done), 0);

        // fill watchdog
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("wd_lock", int'(bus.state), 1);
        for (int i = 0; i < FT; i++) begin
            @(negedge clk);
            chk("wd_fill", int'(bus.state), 2);
        end
        @(negedge clk);
        chk("wd_fault_state", int'(bus.state), 8);
        chk("wd_fault", int'(bus.fault), 1);
        chk("wd_lock_on", int'(bus.door_lock), 1);
        chk("wd_act", int'({bus.motor_on, bus.fill_valve_on, bus.drain_valve_on}), 0);
        repeat (4) begin
            @(negedge clk);
            chk("wd_hold", int'(bus.state), 8);
        end

        // sensor beats watchdog on the final watchdog cycle
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        @(negedge clk);
        repeat (FT) @(negedge clk);
        bus.filled = 1'b1;
        @(negedge clk);
        chk("prio_fill", int'(bus.state), 3);
        bus.filled = 1'b0;
        bus.detergent_added = 1'b1;
        @(negedge clk);
        chk("prio_wash", int'(bus.state), 4);
        bus.detergent_added = 1'b0;
        repeat (WT) @(negedge clk);
        chk("prio_drain_entry", int'(bus.state), 5);
        repeat (DT - 1) @(negedge clk);
        bus.drained = 1'b1;
        @(negedge clk);
        chk("prio_drain", int'(bus.state), 2);
        chk("prio_rinse_left", int'(bus.rinse_left), 0);

        // pause in WASH after two wash cycles
        do_reset();
        set_in(1, 1, 0, 1, 1, 1);
        repeat (4) @(negedge clk);
        chk("pz_wash0", int'(bus.state), 4);
        @(negedge clk);
        chk("pz_wash1_motor", int'(bus.motor_on), 1);
        bus.pause = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pz_state", int'(bus.state), 4);
            chk("pz_motor", int'(bus.motor_on), 0);
        end
        bus.pause = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("pz_resume", int'({bus.state, bus.motor_on}), 9);
        end
        @(negedge clk);
        chk("pz_drain", int'(bus.state), 5);

        // door opened during paused SPIN
        do_reset();
        set_in(1, 1, 0, 1, 1, 1);
        wait_state(6, 40, "door_reach_spin");
        bus.pause = 1'b1;
        bus.door_close = 1'b0;
        @(negedge clk);
        chk("door_fault_state", int'(bus.state), 8);
        chk("door_fault", int'(bus.fault), 1);

        // asynchronous reset in the middle of DRAIN
        do_reset();
        set_in(1, 1, 0, 1, 1, 0);
        wait_state(5, 40, "rst_reach_drain");
        #2 rst = 1'b0;
        #1;
        chk("rst_async_state", int'(bus.state), 0);
        chk("rst_async_outs", int'(dut_vec), 0);
        @(negedge clk);
        set_in(0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_relock", int'(bus.state), 1);
        chk("rst_reload", int'(bus.rinse_left), RC);

        // randomized episodes
        for (int e = 0; e < 20; e++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                set_in($urandom_range(0, 9) != 0, $urandom_range(0, 199) != 0,
                       $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/washing_ctrl_param.md
# washing_ctrl_param

Parametrised washing-machine cycle controller, the next generation of the `washing` FSM. Wash and spin durations are counted internally rather than supplied as timeout inputs, and the rinse-pass count is configurable. Fill and drain operations are supervised by watchdogs, and a pause input is supported. Sits between the front-panel/sensor inputs and the valve, motor and lock drivers.

## Interface
- `WASH_TIME`, default 16: cycles spent in WASH per pass (1..2^CNT_W-1)
- `SPIN_TIME`, default 8: cycles spent in SPIN (1..2^CNT_W-1)
- `FILL_TIMEOUT`, default 32: max cycles in FILL before fault
- `DRAIN_TIMEOUT`, default 32: max cycles in DRAIN before fault
- `RINSE_COUNT`, default 2: water-only rinse passes after the soap pass (0..7)
- `CNT_W`, default 8: timer width
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  cycle request; level-sensitive
- `door_close`  in  1  door sensor, 1 = closed
- `pause`  in  1  freeze current operation while 1
- `filled`  in  1  tub-full sensor
- `detergent_added`  in  1  detergent dispensed acknowledge
- `drained`  in  1  tub-empty sensor
- `door_lock`  out  1  door latch energised
- `motor_on`  out  1  drum motor
- `fill_valve_on`  out  1  inlet valve
- `drain_valve_on`  out  1  drain valve/pump
- `soap_wash`  out  1  soap pass in progress
- `water_wash`  out  1  rinse pass in progress
- `done`  out  1  cycle complete
- `fault`  out  1  watchdog or door fault latched
- `state`  out  4  current state code
- `rinse_left`  out  3  rinse passes remaining

## Operation
- State codes: IDLE=0, LOCK=1, FILL=2, SOAP=3, WASH=4, DRAIN=5, SPIN=6, DONE=7, FAULT=8.
- Timer `cnt` (CNT_W bits) clears on every state change and increments each unpaused cycle.
- IDLE: all outputs 0. `start & door_close` -> LOCK, and `rinse_left` is loaded with RINSE_COUNT.
- LOCK: `door_lock`=1 for exactly one cycle, then -> FILL.
- FILL: `fill_valve_on`=1.
  - `filled` -> SOAP on the soap pass, or -> WASH on a rinse pass.
  - Otherwise, `cnt == FILL_TIMEOUT-1` -> FAULT.
  - `filled` wins over the timeout in the same cycle.
- SOAP: outputs hold, valves off. `detergent_added` -> WASH. No timeout.
- WASH: `motor_on`=1. `cnt == WASH_TIME-1` -> DRAIN.
- DRAIN: `drain_valve_on`=1.
  - `drained`: if `rinse_left` > 0, decrement it and -> FILL (next pass is a rinse); else -> SPIN.
  - `cnt == DRAIN_TIMEOUT-1` without `drained` -> FAULT. `drained` has priority.
- SPIN: `motor_on`=1 and `drain_valve_on`=1. `cnt == SPIN_TIME-1` -> DONE.
- DONE: `done`=1, `door_lock`=0. Remains until `start`=0, then -> IDLE.
- FAULT: `fault`=1, `motor_on`/`fill_valve_on`/`drain_valve_on`=0, `door_lock`=1, `state`=8. Exit only via `reset`.
- `door_lock`=1 in LOCK, FILL, SOAP, WASH, DRAIN, SPIN, FAULT.
- `soap_wash`=1 in FILL/SOAP/WASH/DRAIN of the soap pass. `water_wash`=1 in FILL/WASH/DRAIN of rinse passes. These are mutually exclusive, and both are 0 in IDLE/LOCK/SPIN/DONE/FAULT.
- Pause (states FILL..SPIN): while `pause`=1:
  - state and `cnt` hold;
  - `motor_on`, `fill_valve_on` and `drain_valve_on` forced 0;
  - `door_lock`, `soap_wash`, `water_wash` unchanged;
  - sensor inputs are ignored, and no timeout can fire.
  - `pause` has no effect in IDLE, LOCK, DONE and FAULT.
- Door fault: `door_close`=0 in any state LOCK..SPIN -> FAULT next edge, regardless of `pause`. The door fault takes priority over all other transitions.
- `start` dropping mid-cycle has no effect. Only DONE samples it.

## Timing
- All outputs are Moore-decoded from registered state, `cnt` and `rinse_left`. There is no combinational path from inputs to outputs.
- Reset (`reset`=0, asynchronous) clears state to IDLE, `cnt` to 0, `rinse_left` to 0, and all outputs to 0, mid-operation included. Release is synchronous to the next `clk` edge.
- IDLE -> LOCK on the first edge with `start & door_close`. FILL is entered one edge later.
- Sensor-driven exits take effect on the edge where the sensor is sampled 1.
- WASH occupies exactly WASH_TIME unpaused cycles, and SPIN exactly SPIN_TIME.
- Minimum total cycle, with sensors ready on the first cycle: 1 + (passes×(1+WASH_TIME+1)) + 1 (SOAP) + SPIN_TIME cycles to DONE, where passes = RINSE_COUNT+1.
- Counter compare is an equality compare on CNT_W bits. Parameters must fit in CNT_W; this is checked by the bench, not the RTL.

## Test plan
- Nominal: RINSE_COUNT=1, WASH_TIME=4, SPIN_TIME=3, sensors asserted on the first cycle of each state -> state sequence 1,2,3,4×4,5,2,4×4,5,6×3,7. `soap_wash` is high for pass 1 only, `water_wash` for pass 2. `done`=1 until `start`=0.
- Fill watchdog: FILL_TIMEOUT=5, `filled` never asserted -> FAULT entered 5 cycles after FILL entry with all actuators 0, `door_lock`=1. The FAULT state holds until reset.
- Priority: `filled`=1 on the same cycle `cnt`=FILL_TIMEOUT-1 -> SOAP, not FAULT. The same check applies for `drained` versus DRAIN_TIMEOUT.
- Pause in WASH: WASH_TIME=4, `pause`=1 for 3 cycles after 2 cycles of WASH -> `motor_on`=0 during the pause. WASH lasts 7 cycles total and `cnt` resumes at 2.
- Door open in SPIN: `door_close`=0 with `pause`=1 -> FAULT next edge, `fault`=1.
- Reset mid-DRAIN: `reset`=0 between clock edges -> outputs 0 and `state`=0 immediately. After release, a new `start` reloads `rinse_left`=RINSE_COUNT.
